axis_packet_tx: RTL and testbench

Single-packet AXI4-Stream transmitter: a compute engine fills an on-chip packet buffer through a simple write port, pulses `start` with a word count, and the block streams that many words out on an AXI4-Stream master port, asserting `tlast` on the final word. It is the send-side counterpart to the team's buffered packet receiver. It sits between a result-producing accelerator and the DMA S2MM channel.

---
 rtl/axis_packet_tx.sv | 109 ++++++++++
 tb/tb_axis_packet_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_tx.sv
// rtl/axis_packet_tx.sv - single-packet AXI4-Stream transmitter fed from an on-chip buffer
module axis_packet_tx #(
  parameter int ADDR_WIDTH         = 12,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            m00_axis_aclk,
  input  logic                            m00_axis_aresetn,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   wr_data,
  input  logic                            start,
  input  logic [ADDR_WIDTH:0]             pkt_len,
  output logic                            busy,
  output logic                            done,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic [C_AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]           len;
  logic [ADDR_WIDTH:0]           fetch_cnt;
  logic                          adv;
  logic                          accept;
  logic                          load;
  logic                          finish;

  // Buffer is only writable while idle so an in-flight packet cannot be corrupted.
  always_ff @(posedge m00_axis_aclk) begin
    if (wr_en && state == S_IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    adv       = !m00_axis_tvalid || m00_axis_tready;
    case (state)
      S_IDLE: begin
        if (start && pkt_len != '0) begin
          accept    = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (adv) begin
          if (fetch_cnt < len) begin
            load = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register doubles as the synchronous read port of the buffer.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      len             <= '0;
      fetch_cnt       <= '0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        len       <= pkt_len;
        fetch_cnt <= '0;
      end
      if (load) begin
        m00_axis_tdata  <= mem[fetch_cnt[ADDR_WIDTH-1:0]];
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= (fetch_cnt == len - CNT_ONE);
        fetch_cnt       <= fetch_cnt + CNT_ONE;
      end
      if (finish) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast  <= 1'b0;
      end
    end
  end

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign m00_axis_tstrb = '1;

endmodule

// File: tb/tb_axis_packet_tx.sv
// tb/tb_axis_packet_tx.sv - directed self-checking bench for axis_packet_tx
module tb_axis_packet_tx;

  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic [AW:0]     pkt_len = '0;
  logic            busy;
  logic            done;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tvalid;
  logic            tready = 1'b0;
  logic            tlast;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [DW-1:0] beat_d[$];
  logic          beat_l[$];
  int            beat_cyc[$];
  logic [DW-1:0] exp_q[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  axis_packet_tx #(.ADDR_WIDTH(AW), .C_AXIS_TDATA_WIDTH(DW)) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .pkt_len         (pkt_len),
    .busy            (busy),
    .done            (done),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tready (tready),
    .m00_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded at the falling edge, half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) begin
        beat_d.push_back(tdata);
        beat_l.push_back(tlast);
        beat_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        vectors++;
        assert (tvalid === 1'b1 && tdata === prev_data && tlast === prev_last)
        else begin
          miscompares++;
          $error("FAIL stall_hold: observed v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // mode 0: tready high; mode 1: tready toggles 1,0,0,1,0,1; mode 2: stall then inject start/write mid-packet
  task automatic run_pkt(input int len, input int mode, input string tag);
    logic pat [6];
    bit   got;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beat_d.delete();
    beat_l.delete();
    beat_cyc.delete();
    done_cnt = 0;
    tready   = (mode == 0);
    start    = 1'b1;
    pkt_len  = (AW+1)'(len);
    tick();
    start    = 1'b0;
    wr_en    = 1'b0;
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    check({tag, "_tvalid_lat"}, 64'(tvalid), 64'd0);
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (mode == 1) tready = pat[c % 6];
      if (mode == 2) begin
        tready = (c >= 3);
        if (c == 1) begin
          start   = 1'b1;
          pkt_len = 5'd4;
          wr_en   = 1'b1;
          wr_addr = 4'd2;
          wr_data = 32'hBAD;
        end else begin
          start = 1'b0;
          wr_en = 1'b0;
        end
      end
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    tready = 1'b1;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    tick();
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_done_off"}, 64'(done), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_beats"}, 64'(beat_d.size()), 64'(len));
    for (int i = 0; i < beat_d.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(beat_d[i]), 64'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(beat_l[i]), 64'(i == len - 1));
    end
  endtask

  initial begin
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("tstrb", 64'(tstrb), 64'hF);
    tick();
    rst_n = 1'b1;
    tick();

    write_word(0, 32'h11);
    write_word(1, 32'h22);
    write_word(2, 32'h33);
    write_word(3, 32'h44);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_pkt(4, 0, "p4");
    if (beat_cyc.size() == 4) check("p4_backtoback", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
    else check("p4_backtoback_cnt", 64'(beat_cyc.size()), 64'd4);

    run_pkt(4, 1, "p4_bp");

    run_pkt(4, 2, "p4_busy_ign");
    for (int i = 0; i < 6; i++) tick();
    check("busy_ign_no_second", 64'(busy), 64'd0);
    check("busy_ign_beats", 64'(beat_d.size()), 64'd4);
    run_pkt(4, 0, "p4_mem_kept");

    write_word(0, 32'hDEADBEEF);
    exp_q = '{32'hDEADBEEF};
    run_pkt(1, 0, "p1");

    beat_d.delete();
    start   = 1'b1;
    pkt_len = '0;
    tick();
    start   = 1'b0;
    check("len0_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("len0_tvalid", 64'(tvalid), 64'd0);
    check("len0_beats", 64'(beat_d.size()), 64'd0);

    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 32'hCAFE;
    exp_q   = '{32'hCAFE};
    run_pkt(1, 0, "wr_start");

    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      write_word(i, 32'(i));
      exp_q.push_back(32'(i));
    end
    run_pkt(16, 0, "p16");

    for (int i = 0; i < 4; i++) write_word(i, 32'hA0 + 32'(i));
    beat_d.delete();
    done_cnt = 0;
    tready   = 1'b1;
    start    = 1'b1;
    pkt_len  = 5'd4;
    tick();
    start    = 1'b0;
    for (int c = 0; c < 50 && beat_d.size() < 2; c++) tick();
    check("rst_mid_beats_before", 64'(beat_d.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(tvalid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_tlast", 64'(tlast), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    check("rst_mid_beats_after", 64'(beat_d.size()), 64'd2);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_pkt(4, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
